// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator
//   Core-side load/store initiator for the byte-strobe data-memory interface.
//   Accepts one load/store command at a time, builds the word address, byte
//   strobes and lane-replicated write data, issues the request, waits for the
//   response and returns aligned, sign/zero-extended load data or an error.
//   At most one transaction is outstanding.
//
//   Optional feature: define LSU_RSP_TIMEOUT_EN to abort a response wait after
//   TIMEOUT_CYCLES cycles with res_err_o=1. Without it WAIT_RSP waits forever.
//
// Ports
//   clk_i, rstn_i            clock, synchronous active-low reset
//   cmd_*                    command from execute stage (valid/ready)
//   req_*                    memory request (valid/ready)
//   rsp_*                    memory response (valid/ready)
//   res_*                    result to the core (valid/ready)
module lsu_mem_initiator #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [1:0]              cmd_size_i,
  input  logic                    cmd_unsigned_i,
  input  logic [DATA_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  output logic [DATA_WIDTH-1:0]   req_addr_o,
  output logic [DATA_WIDTH-1:0]   req_data_o,
  output logic [DATA_WIDTH/8-1:0] req_strobe_o,
  output logic                    req_write_o,
  output logic                    req_valid_o,
  input  logic                    req_ready_i,
  input  logic [DATA_WIDTH-1:0]   rsp_data_i,
  input  logic                    rsp_err_i,
  input  logic                    rsp_valid_i,
  output logic                    rsp_ready_o,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [DATA_WIDTH-1:0]   res_data_o,
  output logic                    res_misaligned_o,
  output logic                    res_err_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [1:0]              off_q, off_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0]   req_data_q, req_data_d;
  logic [DATA_WIDTH/8-1:0] req_strobe_q, req_strobe_d;
  logic [DATA_WIDTH-1:0]   res_data_q, res_data_d;
  logic                    res_mis_q, res_mis_d;
  logic                    res_err_q, res_err_d;

`ifdef LSU_RSP_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  // Loads always read the full word; stores enable only the addressed lanes.
  function automatic logic [DATA_WIDTH/8-1:0] calc_strobe(input logic       wr,
                                                          input logic [1:0] sz,
                                                          input logic [1:0] off);
    logic [DATA_WIDTH/8-1:0] s;
    s = 4'b1111;
    if (wr) begin
      case (sz)
        2'd0:    s = 4'b0001 << off;
        2'd1:    s = 4'b0011 << off;
        default: s = 4'b1111;
      endcase
    end
    return s;
  endfunction

  // Replicating the store data into every lane lets the responder pick any lane.
  function automatic logic [DATA_WIDTH-1:0] calc_wdata(input logic [1:0]            sz,
                                                       input logic [DATA_WIDTH-1:0] wd);
    logic [DATA_WIDTH-1:0] d;
    case (sz)
      2'd0:    d = {4{wd[7:0]}};
      2'd1:    d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
    logic m;
    case (sz)
      2'd0:    m = 1'b0;
      2'd1:    m = off[0];
      2'd2:    m = (off != 2'b00);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fmt_load(input logic [DATA_WIDTH-1:0] rd,
                                                     input logic [1:0]            sz,
                                                     input logic                  uns,
                                                     input logic [1:0]            off);
    logic [DATA_WIDTH-1:0] lane;
    logic signed [7:0]     b8;
    logic signed [15:0]    h16;
    logic [DATA_WIDTH-1:0] r;
    lane = rd >> {off, 3'b000};
    b8   = $signed(lane[7:0]);
    h16  = $signed(lane[15:0]);
    case (sz)
      2'd0:    r = uns ? {24'b0, lane[7:0]}  : DATA_WIDTH'(b8);
      2'd1:    r = uns ? {16'b0, lane[15:0]} : DATA_WIDTH'(h16);
      default: r = lane;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    write_d      = write_q;
    req_addr_d   = req_addr_q;
    req_data_d   = req_data_q;
    req_strobe_d = req_strobe_q;
    res_data_d   = res_data_q;
    res_mis_d    = res_mis_q;
    res_err_d    = res_err_q;
`ifdef LSU_RSP_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          write_d      = cmd_write_i;
          size_d       = cmd_size_i;
          uns_d        = cmd_unsigned_i;
          off_d        = cmd_addr_i[1:0];
          req_addr_d   = {cmd_addr_i[DATA_WIDTH-1:2], 2'b00};
          req_data_d   = cmd_write_i ? calc_wdata(cmd_size_i, cmd_wdata_i) : '0;
          req_strobe_d = calc_strobe(cmd_write_i, cmd_size_i, cmd_addr_i[1:0]);
          res_data_d   = '0;
          res_err_d    = 1'b0;
          res_mis_d    = is_misaligned(cmd_size_i, cmd_addr_i[1:0]);
          // Misaligned/illegal commands never reach the memory.
          state_d      = res_mis_d ? DONE : REQ;
        end
      end
      REQ: begin
        if (req_ready_i) begin
          state_d = WAIT_RSP;
`ifdef LSU_RSP_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      WAIT_RSP: begin
        if (rsp_valid_i) begin
          res_err_d  = rsp_err_i;
          res_data_d = (rsp_err_i || write_q) ? '0 : fmt_load(rsp_data_i, size_q, uns_q, off_q);
          state_d    = DONE;
        end
`ifdef LSU_RSP_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          res_err_d  = 1'b1;
          res_data_d = '0;
          state_d    = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      DONE: begin
        if (res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      write_q      <= 1'b0;
      req_addr_q   <= '0;
      req_data_q   <= '0;
      req_strobe_q <= '0;
      res_data_q   <= '0;
      res_mis_q    <= 1'b0;
      res_err_q    <= 1'b0;
`ifdef LSU_RSP_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      write_q      <= write_d;
      req_addr_q   <= req_addr_d;
      req_data_q   <= req_data_d;
      req_strobe_q <= req_strobe_d;
      res_data_q   <= res_data_d;
      res_mis_q    <= res_mis_d;
      res_err_q    <= res_err_d;
`ifdef LSU_RSP_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign cmd_ready_o      = (state_q == IDLE);
  assign req_valid_o      = (state_q == REQ);
  assign rsp_ready_o      = (state_q == WAIT_RSP);
  assign res_valid_o      = (state_q == DONE);
  assign req_addr_o       = req_addr_q;
  assign req_data_o       = req_data_q;
  assign req_strobe_o     = req_strobe_q;
  assign req_write_o      = write_q;
  assign res_data_o       = res_data_q;
  assign res_misaligned_o = res_mis_q;
  assign res_err_o        = res_err_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
module tb_lsu_mem_initiator;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_write_i, cmd_unsigned_i;
  logic [1:0]  cmd_size_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic [31:0] req_addr_o, req_data_o;
  logic [3:0]  req_strobe_o;
  logic        req_write_o, req_valid_o, req_ready_i;
  logic [31:0] rsp_data_i;
  logic        rsp_err_i, rsp_valid_i, rsp_ready_o;
  logic        res_valid_o, res_ready_i, res_misaligned_o, res_err_o;
  logic [31:0] res_data_o;

  typedef struct {
    logic [31:0] data;
    logic        mis;
    logic        err;
  } res_t;

  res_t        sb[$];
  logic [31:0] mem[0:63];
  int          checks = 0;
  int          errors = 0;
  int          lat;

  always #5 clk = ~clk;

  lsu_mem_initiator #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_size_i(cmd_size_i), .cmd_unsigned_i(cmd_unsigned_i), .cmd_addr_i(cmd_addr_i),
    .cmd_wdata_i(cmd_wdata_i),
    .req_addr_o(req_addr_o), .req_data_o(req_data_o), .req_strobe_o(req_strobe_o),
    .req_write_o(req_write_o), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .rsp_data_i(rsp_data_i), .rsp_err_i(rsp_err_i), .rsp_valid_i(rsp_valid_i),
    .rsp_ready_o(rsp_ready_o),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
    .res_misaligned_o(res_misaligned_o), .res_err_o(res_err_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the result, checks latency and hold under backpressure,
  // then pops the scoreboard at the result handshake.
  task automatic wait_res(input int exp_lat, input int res_stall);
    int          n;
    logic [31:0] hd;
    logic        hm, he;
    res_t        e;
    n = 0;
    while (res_valid_o !== 1'b1 && n < 40) begin
      tick();
      lat++;
      n++;
    end
    chk("res_seen", {31'b0, res_valid_o}, 32'd1);
    chk("res_latency", lat, exp_lat);
    hd = res_data_o;
    hm = res_misaligned_o;
    he = res_err_o;
    res_ready_i = 1'b0;
    for (int i = 0; i < res_stall; i++) begin
      tick();
      chk("res_hold_valid", {31'b0, res_valid_o}, 32'd1);
      chk("res_hold_data", res_data_o, hd);
      chk("res_hold_flags", {30'b0, res_misaligned_o, res_err_o}, {30'b0, hm, he});
      chk("cmd_ready_busy", {31'b0, cmd_ready_o}, 32'd0);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("res_data", res_data_o, e.data);
      chk("res_misaligned", {31'b0, res_misaligned_o}, {31'b0, e.mis});
      chk("res_err", {31'b0, res_err_o}, {31'b0, e.err});
    end else begin
      chk("sb_underflow", 32'(sb.size()), 32'd1);
    end
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
    chk("res_valid_after_hs", {31'b0, res_valid_o}, 32'd0);
    chk("cmd_ready_after_hs", {31'b0, cmd_ready_o}, 32'd1);
  endtask

  task automatic run_cmd(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] e_raddr, input logic [31:0] e_rdata,
                         input logic [3:0] e_strb, input logic [31:0] e_res,
                         input logic e_mis, input logic e_err, input logic rerr,
                         input int req_stall, input int res_stall);
    res_t e;
    e.data = e_res;
    e.mis  = e_mis;
    e.err  = e_err;
    sb.push_back(e);
    chk("cmd_ready_idle", {31'b0, cmd_ready_o}, 32'd1);
    cmd_valid_i    = 1'b1;
    cmd_write_i    = wr;
    cmd_size_i     = sz;
    cmd_unsigned_i = uns;
    cmd_addr_i     = addr;
    cmd_wdata_i    = wdata;
    tick();
    cmd_valid_i = 1'b0;
    lat = 1;
    if (e_mis) begin
      chk("mis_no_req", {31'b0, req_valid_o}, 32'd0);
      wait_res(1, res_stall);
    end else begin
      chk("req_valid", {31'b0, req_valid_o}, 32'd1);
      chk("req_addr", req_addr_o, e_raddr);
      chk("req_strobe", {28'b0, req_strobe_o}, {28'b0, e_strb});
      chk("req_write", {31'b0, req_write_o}, {31'b0, wr});
      if (wr) chk("req_data", req_data_o, e_rdata);
      req_ready_i = 1'b0;
      for (int i = 0; i < req_stall; i++) begin
        tick();
        lat++;
        chk("req_hold_valid", {31'b0, req_valid_o}, 32'd1);
        chk("req_hold_addr", req_addr_o, e_raddr);
        chk("req_hold_strobe", {28'b0, req_strobe_o}, {28'b0, e_strb});
        chk("cmd_ready_busy", {31'b0, cmd_ready_o}, 32'd0);
      end
      req_ready_i = 1'b1;
      tick();
      lat++;
      req_ready_i = 1'b0;
      chk("rsp_ready", {31'b0, rsp_ready_o}, 32'd1);
      chk("req_valid_drop", {31'b0, req_valid_o}, 32'd0);
      // Responder: one-cycle read of the addressed word, strobed write.
      rsp_valid_i = 1'b1;
      rsp_err_i   = rerr;
      rsp_data_i  = mem[req_addr_o[7:2]];
      if (req_write_o && !rerr) begin
        for (int b = 0; b < 4; b++)
          if (req_strobe_o[b]) mem[req_addr_o[7:2]][8*b +: 8] = req_data_o[8*b +: 8];
      end
      tick();
      lat++;
      rsp_valid_i = 1'b0;
      rsp_err_i   = 1'b0;
      rsp_data_i  = 32'h0;
      wait_res(3 + req_stall, res_stall);
    end
  endtask

  initial begin
    res_t e;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    rstn_i = 1'b0;
    cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_size_i = 2'd0; cmd_unsigned_i = 1'b0;
    cmd_addr_i = 32'h0; cmd_wdata_i = 32'h0;
    req_ready_i = 1'b0; rsp_data_i = 32'h0; rsp_err_i = 1'b0; rsp_valid_i = 1'b0;
    res_ready_i = 1'b0;
    tick();
    tick();
    chk("rst_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
    chk("rst_valids", {29'b0, req_valid_o, rsp_ready_o, res_valid_o}, 32'd0);
    chk("rst_res", {res_data_o[29:0], res_misaligned_o, res_err_o}, 32'd0);
    chk("rst_req", req_addr_o | req_data_o | {28'b0, req_strobe_o} | {31'b0, req_write_o}, 32'd0);
    rstn_i = 1'b1;
    tick();

    // Word stores
    run_cmd(1, 2, 0, 32'h10, 32'hDEADBEEF, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 0, 0, 0, 0, 0);
    run_cmd(1, 2, 0, 32'h10, 32'h8899AABB, 32'h10, 32'h8899AABB, 4'b1111, 32'h0, 0, 0, 0, 0, 0);
    // Loads of 0x8899AABB, signed byte with request and result backpressure
    run_cmd(0, 0, 0, 32'h13, 32'h0, 32'h10, 32'h0, 4'b1111, 32'hFFFFFF88, 0, 0, 0, 3, 2);
    run_cmd(0, 1, 1, 32'h12, 32'h0, 32'h10, 32'h0, 4'b1111, 32'h00008899, 0, 0, 0, 0, 0);
    run_cmd(0, 1, 0, 32'h10, 32'h0, 32'h10, 32'h0, 4'b1111, 32'hFFFFAABB, 0, 0, 0, 0, 0);
    run_cmd(0, 0, 1, 32'h11, 32'h0, 32'h10, 32'h0, 4'b1111, 32'h000000AA, 0, 0, 0, 0, 0);
    run_cmd(0, 2, 0, 32'h10, 32'h0, 32'h10, 32'h0, 4'b1111, 32'h8899AABB, 0, 0, 0, 0, 0);
    // Sub-word stores and readback
    run_cmd(1, 0, 0, 32'h21, 32'h0000005A, 32'h20, 32'h5A5A5A5A, 4'b0010, 32'h0, 0, 0, 0, 0, 0);
    run_cmd(0, 2, 0, 32'h20, 32'h0, 32'h20, 32'h0, 4'b1111, 32'h00005A00, 0, 0, 0, 0, 0);
    run_cmd(1, 1, 0, 32'h22, 32'hABCD1234, 32'h20, 32'h12341234, 4'b1100, 32'h0, 0, 0, 0, 0, 0);
    run_cmd(0, 2, 0, 32'h20, 32'h0, 32'h20, 32'h0, 4'b1111, 32'h12345A00, 0, 0, 0, 0, 0);
    run_cmd(0, 0, 0, 32'h20, 32'h0, 32'h20, 32'h0, 4'b1111, 32'h00000000, 0, 0, 0, 0, 0);
    // Responder error
    run_cmd(0, 2, 0, 32'h10, 32'h0, 32'h10, 32'h0, 4'b1111, 32'h0, 0, 1, 1, 0, 0);
    // Misaligned and illegal
    run_cmd(0, 2, 0, 32'h06, 32'h0, 32'h0, 32'h0, 4'b0, 32'h0, 1, 0, 0, 0, 0);
    run_cmd(0, 3, 0, 32'h10, 32'h0, 32'h0, 32'h0, 4'b0, 32'h0, 1, 0, 0, 0, 1);
    run_cmd(1, 1, 0, 32'h11, 32'h0, 32'h0, 32'h0, 4'b0, 32'h0, 1, 0, 0, 0, 0);

    // Stray response in IDLE is ignored
    rsp_valid_i = 1'b1;
    rsp_data_i  = 32'h12345678;
    tick();
    rsp_valid_i = 1'b0;
    chk("stray_idle_res", {31'b0, res_valid_o}, 32'd0);
    chk("stray_idle_ready", {31'b0, cmd_ready_o}, 32'd1);

    // Reset during WAIT_RSP drops the transaction
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_size_i = 2'd2; cmd_addr_i = 32'h10;
    tick();
    cmd_valid_i = 1'b0;
    req_ready_i = 1'b1;
    tick();
    req_ready_i = 1'b0;
    chk("rstw_in_wait", {31'b0, rsp_ready_o}, 32'd1);
    rstn_i = 1'b0;
    tick();
    rstn_i = 1'b1;
    chk("rstw_valids", {29'b0, req_valid_o, rsp_ready_o, res_valid_o}, 32'd0);
    chk("rstw_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
    chk("rstw_req_addr", req_addr_o, 32'h0);
    tick();
    chk("rstw_idle", {31'b0, cmd_ready_o}, 32'd1);

`ifdef LSU_RSP_TIMEOUT_EN
    e.data = 32'h0; e.mis = 1'b0; e.err = 1'b1;
    sb.push_back(e);
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_size_i = 2'd2; cmd_addr_i = 32'h10;
    tick();
    cmd_valid_i = 1'b0;
    req_ready_i = 1'b1;
    tick();
    req_ready_i = 1'b0;
    lat = 2;
    wait_res(2 + TMO, 1);
    rsp_valid_i = 1'b1;
    rsp_data_i  = 32'hCAFEF00D;
    tick();
    rsp_valid_i = 1'b0;
    chk("tmo_stray_res", {31'b0, res_valid_o}, 32'd0);
    chk("tmo_stray_ready", {31'b0, cmd_ready_o}, 32'd1);
`else
    e.data = 32'h8899AABB; e.mis = 1'b0; e.err = 1'b0;
    sb.push_back(e);
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_size_i = 2'd2; cmd_addr_i = 32'h10;
    tick();
    cmd_valid_i = 1'b0;
    req_ready_i = 1'b1;
    tick();
    req_ready_i = 1'b0;
    lat = 2;
    for (int i = 0; i < 20; i++) begin
      chk("nowait_rsp_ready", {31'b0, rsp_ready_o}, 32'd1);
      chk("nowait_res_valid", {31'b0, res_valid_o}, 32'd0);
      tick();
      lat++;
    end
    rsp_valid_i = 1'b1;
    rsp_data_i  = mem[4];
    tick();
    lat++;
    rsp_valid_i = 1'b0;
    wait_res(23, 0);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
